alu_seq: RTL and testbench

Sequential, parametrised successor to the combinational ALU_J datapath. It takes one operation at a time over a valid/ready input handshake and executes single-cycle logic and arithmetic ops. It also runs iterative multi-cycle shifts and a new shift-add multiply, then holds a registered result and status word until the downstream stage accepts it. It sits between instruction decode and the register-file write-back, and keeps the existing opcode encoding and status-bit layout.

---
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_seq.sv | 182 ++++++++++++++++++
 tb/tb_alu_seq.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle between decode, the sequential ALU and write-back.
interface alu_seq_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PARAM_BITS = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4:0]            opcode;
    logic [DATA_WIDTH-1:0] operand1;
    logic [DATA_WIDTH-1:0] operand2;
    logic [PARAM_BITS-1:0] param;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] result_hi;
    logic [5:0]            status;

    // Issuer side: drives requests, consumes results.
    modport master (
        output in_valid, opcode, operand1, operand2, param, out_ready,
        input  in_ready, out_valid, result, result_hi, status
    );

    // ALU side.
    modport slave (
        input  in_valid, opcode, operand1, operand2, param, out_ready,
        output in_ready, out_valid, result, result_hi, status
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, iterative 1-bit-per-cycle shifts and an
// unsigned shift-add multiplier. Result and status are registered and held until accepted.
module alu_seq #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PARAM_BITS = 8
) (
    input logic      clock,
    input logic      reset,
    alu_seq_if.slave bus
);
    localparam int unsigned W    = DATA_WIDTH;
    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
    // Wide enough that neither param nor DATA_WIDTH truncates in the clamp compare.
    localparam int unsigned CmpW = PARAM_BITS + 32;

    localparam logic [4:0] OpAdd = 5'h01;
    localparam logic [4:0] OpSub = 5'h02;
    localparam logic [4:0] OpAnd = 5'h03;
    localparam logic [4:0] OpOr  = 5'h04;
    localparam logic [4:0] OpNot = 5'h05;
    localparam logic [4:0] OpXor = 5'h06;
    localparam logic [4:0] OpShl = 5'h07;
    localparam logic [4:0] OpShr = 5'h08;
    localparam logic [4:0] OpMul = 5'h0A;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e          state_q, state_d;
    logic [4:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [W-1:0]    shreg_q, shreg_d;
    logic [2*W-1:0]  acc_q, acc_d;       // {high partial sum, remaining multiplier bits}
    logic [CntW-1:0] cnt_q, cnt_d;       // iterations still to run in EXEC
    logic            carry_q, carry_d;   // last bit shifted out
    logic [W-1:0]    result_q, result_d, result_hi_q, result_hi_d;
    logic [5:0]      status_q, status_d;

    logic [PARAM_BITS-1:0] param_in;
    logic [W:0]            add_sum, mul_sum;
    logic [W-1:0]          fin_res, fin_hi;
    logic                  fin_c, fin_u, fin_z, fin_cmp, fin_zres;

    assign param_in = bus.param;
    assign add_sum  = {1'b0, a_q} + {1'b0, b_q};
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});

    // Final result/flags from the latched operands and the iterated shift/multiply state.
    always_comb begin
        fin_res  = '0;
        fin_hi   = '0;
        fin_c    = 1'b0;
        fin_u    = 1'b0;
        fin_cmp  = 1'b0;
        fin_zres = 1'b1;
        case (op_q)
            OpAdd: begin
                fin_res = add_sum[W-1:0];
                fin_c   = add_sum[W];
                fin_cmp = 1'b1;
            end
            OpSub: begin
                fin_res = a_q - b_q;
                fin_u   = (b_q > a_q);
                fin_cmp = 1'b1;
            end
            OpAnd: begin fin_res = a_q & b_q; fin_cmp = 1'b1; end
            OpOr:  begin fin_res = a_q | b_q; fin_cmp = 1'b1; end
            OpXor: begin fin_res = a_q ^ b_q; fin_cmp = 1'b1; end
            OpNot: fin_res = ~b_q;
            OpShl, OpShr: begin
                fin_res = shreg_q;
                fin_c   = carry_q;
            end
            OpMul: begin
                fin_res = acc_q[W-1:0];
                fin_hi  = acc_q[2*W-1:W];
                fin_c   = |acc_q[2*W-1:W];
                fin_cmp = 1'b1;
            end
            default: fin_zres = 1'b0;  // NOP and reserved codes report all-zero status
        endcase
        fin_z = (op_q == OpMul) ? (acc_q == '0) : (fin_zres && (fin_res == '0));
    end

    // Next-state: accept in IDLE, iterate in EXEC until the count is spent, hold in DONE.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        shreg_d     = shreg_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        status_d    = status_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    op_d    = bus.opcode;
                    a_d     = bus.operand1;
                    b_d     = bus.operand2;
                    shreg_d = bus.operand1;
                    acc_d   = {{W{1'b0}}, bus.operand2};
                    carry_d = 1'b0;
                    case (bus.opcode)
                        OpShl, OpShr: begin
                            if (CmpW'(param_in) >= CmpW'(DATA_WIDTH)) cnt_d = CntW'(DATA_WIDTH);
                            else                                      cnt_d = CntW'(param_in);
                        end
                        OpMul:   cnt_d = CntW'(DATA_WIDTH);  // fixed, even for zero operands
                        default: cnt_d = '0;
                    endcase
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                    case (op_q)
                        OpMul: acc_d = {mul_sum, acc_q[W-1:1]};
                        OpShl: begin
                            carry_d = shreg_q[W-1];
                            shreg_d = {shreg_q[W-2:0], 1'b0};
                        end
                        OpShr: begin
                            carry_d = shreg_q[0];
                            shreg_d = {1'b0, shreg_q[W-1:1]};
                        end
                        default: ;
                    endcase
                end else begin
                    result_d    = fin_res;
                    result_hi_d = fin_hi;
                    status_d    = {fin_cmp && (a_q < b_q), fin_cmp && (a_q > b_q),
                                   fin_cmp && (a_q == b_q), fin_z, fin_u, fin_c};
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            shreg_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            shreg_q     <= shreg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            status_q    <= status_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.status    = status_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vectors with literal expectations plus randomized ops,
// all outputs compared every cycle against an arithmetic reference model.
module tb_alu_seq;
    localparam int unsigned W  = 8;
    localparam int unsigned PB = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    alu_seq_if #(.DATA_WIDTH(W), .PARAM_BITS(PB)) bus ();

    alu_seq #(.DATA_WIDTH(W), .PARAM_BITS(PB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_issued = 0;
    int dut_acc  = 0;
    int dut_cmp  = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: what an op must produce and how many cycles it takes, in plain arithmetic.
    function automatic void ref_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [PB-1:0] p, output logic [W-1:0] r,
                                   output logic [W-1:0] h, output logic [5:0] s, output int lat);
        logic [2*W-1:0] wide;
        int   n;
        logic c, u, z, cmp, live;
        n    = (int'(p) >= int'(W)) ? int'(W) : int'(p);
        wide = '0; r = '0; h = '0;
        c = 1'b0; u = 1'b0; cmp = 1'b0; live = 1'b1; lat = 2;
        case (op)
            5'h01: begin wide = {{W{1'b0}}, a} + {{W{1'b0}}, b}; r = wide[W-1:0]; c = wide[W]; cmp = 1; end
            5'h02: begin r = a - b; u = (b > a); cmp = 1; end
            5'h03: begin r = a & b; cmp = 1; end
            5'h04: begin r = a | b; cmp = 1; end
            5'h05: r = ~b;
            5'h06: begin r = a ^ b; cmp = 1; end
            5'h07: begin
                wide = {{W{1'b0}}, a} << n; r = wide[W-1:0]; c = (n != 0) && wide[W]; lat = 2 + n;
            end
            5'h08: begin
                wide = {a, {W{1'b0}}} >> n; r = wide[2*W-1:W]; c = (n != 0) && wide[W-1]; lat = 2 + n;
            end
            5'h0A: begin
                wide = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                r = wide[W-1:0]; h = wide[2*W-1:W]; c = (h != 0); cmp = 1; lat = 2 + W;
            end
            default: live = 1'b0;
        endcase
        z = (op == 5'h0A) ? (wide == 0) : (live && r == 0);
        s = {cmp && (a < b), cmp && (a > b), cmp && (a == b), z, u, c};
    endfunction

    // Cycle-level expectation: idle until accept, outputs appear lat cycles after the
    // accept cycle, held until taken; reset clears everything.
    logic         m_idle, m_valid;
    int           m_left;
    logic [W-1:0] exp_res, exp_hi, pend_res, pend_hi;
    logic [5:0]   exp_st, pend_st;

    always @(posedge clock) begin : model
        logic [W-1:0] r, h;
        logic [5:0]   s;
        int           lat;
        if (reset) begin
            m_idle <= 1'b1; m_valid <= 1'b0; m_left <= 0;
            exp_res <= '0; exp_hi <= '0; exp_st <= '0;
        end else if (m_idle) begin
            if (bus.in_valid) begin
                ref_op(bus.opcode, bus.operand1, bus.operand2, bus.param, r, h, s, lat);
                pend_res <= r; pend_hi <= h; pend_st <= s;
                m_left <= lat - 1; m_idle <= 1'b0;
            end
        end else if (m_left > 0) begin
            if (m_left == 1) begin
                exp_res <= pend_res; exp_hi <= pend_hi; exp_st <= pend_st; m_valid <= 1'b1;
            end
            m_left <= m_left - 1;
        end else if (bus.out_ready) begin
            m_valid <= 1'b0; m_idle <= 1'b1;
        end
    end

    // Handshake counters observed on the DUT pins.
    always @(posedge clock) begin
        if (!reset && bus.in_valid && bus.in_ready)   dut_acc <= dut_acc + 1;
        if (!reset && bus.out_valid && bus.out_ready) dut_cmp <= dut_cmp + 1;
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clock) begin
        if (chk_en && !reset) begin
            check("in_ready",  bus.in_ready,  m_idle);
            check("out_valid", bus.out_valid, m_valid);
            check("result",    bus.result,    exp_res);
            check("result_hi", bus.result_hi, exp_hi);
            check("status",    bus.status,    exp_st);
        end
    end

    task automatic scramble();
        bus.in_valid = 1'($urandom);
        bus.opcode   = 5'($urandom);
        bus.operand1 = W'($urandom);
        bus.operand2 = W'($urandom);
        bus.param    = PB'($urandom);
    endtask

    // Issue one op, wait for the result, hold it under backpressure, then take it.
    task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [PB-1:0] p, input int hold, output int lat);
        logic [W-1:0] er, eh;
        logic [5:0]   es;
        int           elat, guard;
        ref_op(op, a, b, p, er, eh, es, elat);
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin @(posedge clock); #1; guard++; end
        bus.in_valid = 1'b1; bus.opcode = op; bus.operand1 = a; bus.operand2 = b; bus.param = p;
        @(posedge clock); #1;
        n_issued++;
        scramble();
        lat = 1; guard = 0;
        while (bus.out_valid !== 1'b1 && guard < 4 * W) begin
            @(posedge clock); #1; scramble(); lat++; guard++;
        end
        check("out_valid_seen", bus.out_valid, 1'b1);
        check("latency", lat, elat);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1; scramble();
            check("hold_result", bus.result, er);
            check("hold_hi", bus.result_hi, eh);
            check("hold_status", bus.status, es);
            check("hold_in_ready", bus.in_ready, 1'b0);
            check("hold_out_valid", bus.out_valid, 1'b1);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        logic [W-1:0] r, h;
        logic [5:0]   s;
        int           lat, c0, a0;
        logic [4:0]   op_tab [10];
        logic [4:0]   op;
        logic [W-1:0] a, b;
        logic [PB-1:0] p;

        op_tab = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h0A, 5'h00};
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.opcode = '0; bus.operand1 = '0; bus.operand2 = '0; bus.param = '0;

        // Pin the model against hand-computed vectors.
        ref_op(5'h01, 8'd200, 8'd100, 8'd0, r, h, s, lat);
        check("model_add_r", r, 8'h2C); check("model_add_s", s, 6'b01_0001); check("model_add_lat", lat, 2);
        ref_op(5'h02, 8'd3, 8'd5, 8'd0, r, h, s, lat);
        check("model_sub_r", r, 8'hFE); check("model_sub_s", s, 6'b10_0010);
        ref_op(5'h08, 8'hFF, 8'hFF, 8'd10, r, h, s, lat);
        check("model_shr_r", r, 8'h00); check("model_shr_s", s, 6'b00_0101); check("model_shr_lat", lat, 10);
        ref_op(5'h0A, 8'd16, 8'd16, 8'd0, r, h, s, lat);
        check("model_mul_hi", h, 8'h01); check("model_mul_s", s, 6'b00_1001); check("model_mul_lat", lat, 10);

        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_result", bus.result, 8'h00);
        check("rst_result_hi", bus.result_hi, 8'h00);
        check("rst_status", bus.status, 6'b0);
        reset = 1'b0;
        chk_en = 1'b1;

        run_op(5'h01, 8'd200, 8'd100, 8'd0, 0, lat);
        check("add_result", bus.result, 8'h2C); check("add_status", bus.status, 6'b01_0001);
        check("add_lat", lat, 2);
        run_op(5'h02, 8'd3, 8'd5, 8'd0, 0, lat);
        check("sub_result", bus.result, 8'hFE); check("sub_status", bus.status, 6'b10_0010);
        run_op(5'h02, 8'd7, 8'd7, 8'd0, 0, lat);
        check("sub_eq_result", bus.result, 8'h00); check("sub_eq_status", bus.status, 6'b00_1100);
        run_op(5'h08, 8'hFF, 8'h00, 8'd10, 0, lat);
        check("shr_result", bus.result, 8'h00); check("shr_status", bus.status, 6'b00_0101);
        check("shr_lat", lat, 10);
        run_op(5'h07, 8'h81, 8'h00, 8'd1, 0, lat);
        check("shl_result", bus.result, 8'h02); check("shl_status", bus.status, 6'b00_0001);
        check("shl_lat", lat, 3);
        run_op(5'h07, 8'h81, 8'h00, 8'd255, 0, lat);
        check("shl255_lat", lat, 10); check("shl255_result", bus.result, 8'h00);
        run_op(5'h0A, 8'd16, 8'd16, 8'd0, 0, lat);
        check("mul_result", bus.result, 8'h00); check("mul_hi", bus.result_hi, 8'h01);
        check("mul_status", bus.status, 6'b00_1001); check("mul_lat", lat, 10);
        run_op(5'h0A, 8'd0, 8'd77, 8'd0, 0, lat);
        check("mul0_lat", lat, 10); check("mul0_status", bus.status, 6'b10_0100);

        c0 = dut_cmp; a0 = dut_acc;
        run_op(5'h0A, 8'd15, 8'd17, 8'd0, 5, lat);
        check("bp_result", bus.result, 8'hFF); check("bp_hi", bus.result_hi, 8'h00);
        check("bp_status", bus.status, 6'b10_0000);
        check("bp_one_completion", dut_cmp - c0, 1);
        check("bp_one_accept", dut_acc - a0, 1);

        // Abort a multiply on its 4th EXEC cycle.
        bus.in_valid = 1'b1; bus.opcode = 5'h0A; bus.operand1 = 8'd99; bus.operand2 = 8'd45;
        @(posedge clock); #1;
        n_issued++;
        bus.in_valid = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        reset = 1'b1;
        @(posedge clock); #1;
        check("abort_out_valid", bus.out_valid, 1'b0);
        check("abort_result", bus.result, 8'h00);
        check("abort_status", bus.status, 6'b0);
        check("abort_in_ready", bus.in_ready, 1'b1);
        reset = 1'b0;
        run_op(5'h01, 8'd1, 8'd1, 8'd0, 0, lat);
        check("post_abort_result", bus.result, 8'h02);
        check("post_abort_status", bus.status, 6'b00_1000);
        run_op(5'h09, 8'd5, 8'd9, 8'd0, 0, lat);
        check("val_result", bus.result, 8'h00); check("val_status", bus.status, 6'b0);

        for (int i = 0; i < 120; i++) begin
            op = ($urandom_range(0, 5) == 0) ? 5'($urandom) : op_tab[$urandom_range(0, 9)];
            case ($urandom_range(0, 3))
                0: a = '0;
                1: a = '1;
                default: a = W'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: b = '0;
                1: b = a;
                default: b = W'($urandom);
            endcase
            p = ($urandom_range(0, 3) == 0) ? 8'hFF : PB'($urandom_range(0, 10));
            run_op(op, a, b, p, $urandom_range(0, 2), lat);
        end

        check("total_accepts", dut_acc, n_issued);
        check("total_completions", dut_cmp, n_issued - 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
